// File: rtl/mult_cpa_pipe_if.sv
// Handshake bundle for the multiplier's final carry-propagate stage.
// master drives the redundant vectors and consumes products; slave is the adder.
interface mult_cpa_pipe_if #(
    parameter int W = 8
);
    logic [2*W-1:0] in_sum;
    logic [2*W-1:0] in_carry;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] out_product;
    logic           out_ovf;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output in_sum, in_carry, in_valid, out_ready,
        input  in_ready, out_product, out_ovf, out_valid
    );

    modport slave (
        input  in_sum, in_carry, in_valid, out_ready,
        output in_ready, out_product, out_ovf, out_valid
    );
endinterface

// File: rtl/mult_cpa_pipe.sv
// Two-stage carry-propagate adder that resolves the array's sum/carry vectors
// into a binary product, split at bit W, with valid/ready on both sides.
module mult_cpa_pipe #(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mult_cpa_pipe_if.slave  bus
);
    logic         vld_p1;
    logic [W-1:0] lo_p1;
    logic         c1_p1;
    logic [W-1:0] sum_hi_p1;
    logic [W-1:0] carry_hi_p1;

    logic           vld_p2;
    logic [2*W-1:0] product_p2;
    logic           ovf_p2;

    logic       s2_ready;
    logic       accept;
    logic       advance;
    logic [W:0] lo_add;
    logic [W:0] hi_add;

    function automatic logic [W:0] add_w(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic         cin);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    assign s2_ready    = !vld_p2 || bus.out_ready;
    assign bus.in_ready = !vld_p1 || s2_ready;
    assign accept      = bus.in_valid && bus.in_ready;
    assign advance     = vld_p1 && s2_ready;

    assign lo_add = add_w(bus.in_sum[W-1:0], bus.in_carry[W-1:0], 1'b0);
    assign hi_add = add_w(sum_hi_p1, carry_hi_p1, c1_p1);

    // Stage 1: low half resolved, high halves parked with the split carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            lo_p1       <= '0;
            c1_p1       <= 1'b0;
            sum_hi_p1   <= '0;
            carry_hi_p1 <= '0;
        end else begin
            vld_p1 <= accept || (vld_p1 && !s2_ready);
            if (accept) begin
                lo_p1       <= lo_add[W-1:0];
                c1_p1       <= lo_add[W];
                sum_hi_p1   <= bus.in_sum[2*W-1:W];
                carry_hi_p1 <= bus.in_carry[2*W-1:W];
            end
        end
    end

    // Stage 2: high half resolved; output register doubles as the skid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2     <= 1'b0;
            product_p2 <= '0;
            ovf_p2     <= 1'b0;
        end else begin
            vld_p2 <= advance || (vld_p2 && !bus.out_ready);
            if (advance) begin
                product_p2 <= {hi_add[W-1:0], lo_p1};
                ovf_p2     <= hi_add[W];
            end
        end
    end

    assign bus.out_valid   = vld_p2;
    assign bus.out_product = product_p2;
    assign bus.out_ovf     = ovf_p2;
endmodule
